// File: rtl/sisc_pkg.sv
// Shared SISC definitions: arbiter FSM encodings, requester ids and the
// address/data width defaults used by ctrl, the datapath and the memory arbiter.
package sisc_pkg;

    localparam int SISC_AW = 16;
    localparam int SISC_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_DM = 1'b1
    } req_id_t;

endpackage

// File: rtl/sisc_rr_pick2.sv
// Two-way round-robin pick between the fetch and data requesters.
// reqs[REQ_IF] / reqs[REQ_DM] are the pending requests, last is the id that
// won the previous access; winner is only meaningful when some request is set.
module sisc_rr_pick2
    import sisc_pkg::*;
(
    input  logic [1:0] reqs,
    input  logic       last,
    output logic       winner
);

    // A lone request wins outright; a tie goes to the port that did not win last time.
    always_comb begin
        if (reqs[REQ_IF] && reqs[REQ_DM]) begin
            winner = ~last;
        end else if (reqs[REQ_DM]) begin
            winner = REQ_DM;
        end else begin
            winner = REQ_IF;
        end
    end

endmodule

// File: rtl/sisc_mem_arb.sv
// Single-port memory arbiter between instruction fetch (IF) and load/store (DM).
// Each access runs IDLE -> ACCESS -> WAIT (WAIT_CYC cycles, skipped when 0)
// -> DONE, and the granted port sees a one-cycle ack in DONE.
module sisc_mem_arb
    import sisc_pkg::*;
#(
    parameter int AW       = SISC_AW,
    parameter int DW       = SISC_DW,
    parameter int WAIT_CYC = 1
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ack,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    // Value loaded into the wait counter on grant; the WAIT state ends when it reaches 0.
    localparam logic [3:0] WAIT_LAST = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    arb_state_t    state;
    arb_state_t    state_nxt;
    req_id_t       grant;
    req_id_t       last_grant;
    logic          pick;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [DW-1:0] wdata_q;
    logic [3:0]    wait_cnt;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] dm_rdata_q;
    logic          start;

    assign start = (state == ST_IDLE) && (if_req || dm_req);

    sisc_rr_pick2 u_pick (
        .reqs   ({dm_req, if_req}),
        .last   (last_grant),
        .winner (pick)
    );

    // State register; reset abandons any access in flight.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: one ACCESS cycle, optional WAIT, one DONE cycle.
    // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (if_req || dm_req) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = (WAIT_CYC > 0) ? ST_WAIT : ST_DONE;
            ST_WAIT:   if (wait_cnt == 4'd0) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Latch the winner's request on grant; later changes on the request ports are ignored.
    // NOTE: these are a handful of control/data flops, not a memory array, so they all get reset.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            grant   <= REQ_IF;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else if (start) begin
            grant   <= req_id_t'(pick);
            addr_q  <= (pick == REQ_DM) ? dm_addr : if_addr;
            we_q    <= (pick == REQ_DM) ? dm_we : 1'b0;
            wdata_q <= (pick == REQ_DM) ? dm_wdata : '0;
        end
    end

    // Wait-cycle counter: armed on grant, counts down through the WAIT state.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            wait_cnt <= 4'd0;
        end else if (start) begin
            wait_cnt <= WAIT_LAST;
        end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Completion bookkeeping: remember who was served and capture load data.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            last_grant <= REQ_DM;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else if (state == ST_DONE) begin
            last_grant <= grant;
            if (!we_q) begin
                if (grant == REQ_IF) begin
                    if_rdata_q <= mem_rdata;
                end else begin
                    dm_rdata_q <= mem_rdata;
                end
            end
        end
    end

    // Output decode from the current state; memory is only driven in ACCESS and WAIT.
    // During a load's ack cycle the memory word is forwarded so rdata is valid with the
    // ack; the register then holds it for the following cycles.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_ack    = 1'b0;
        dm_ack    = 1'b0;
        case (state)
            ST_ACCESS: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            ST_WAIT: begin
                mem_en   = 1'b1;
                mem_addr = addr_q;
            end
            ST_DONE: begin
                if_ack = (grant == REQ_IF);
                dm_ack = (grant == REQ_DM);
            end
            default: ;
        endcase
        if_rdata = (if_ack && !we_q) ? mem_rdata : if_rdata_q;
        dm_rdata = (dm_ack && !we_q) ? mem_rdata : dm_rdata_q;
        busy     = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_sisc_mem_arb.sv
// Directed bench for sisc_mem_arb: instance A uses WAIT_CYC=1, instance B uses
// WAIT_CYC=0. Each instance has a small word memory that registers read data
// on every enabled cycle, so the word is valid in the arbiter's DONE cycle.
module tb_sisc_mem_arb;

    logic clk = 1'b0;
    logic rst_f;
    always #5 clk = ~clk;

    logic        a_if_req, a_if_ack, a_dm_req, a_dm_we, a_dm_ack, a_mem_en, a_mem_we, a_busy;
    logic [15:0] a_if_addr, a_dm_addr, a_mem_addr;
    logic [31:0] a_if_rdata, a_dm_wdata, a_dm_rdata, a_mem_wdata, a_mem_rdata;
    logic        b_if_req, b_if_ack, b_dm_req, b_dm_we, b_dm_ack, b_mem_en, b_mem_we, b_busy;
    logic [15:0] b_if_addr, b_dm_addr, b_mem_addr;
    logic [31:0] b_if_rdata, b_dm_wdata, b_dm_rdata, b_mem_wdata, b_mem_rdata;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];

    sisc_mem_arb #(.AW(16), .DW(32), .WAIT_CYC(1)) u_dut_a (
        .clk(clk), .rst_f(rst_f),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_ack(a_if_ack), .if_rdata(a_if_rdata),
        .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
        .dm_ack(a_dm_ack), .dm_rdata(a_dm_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    sisc_mem_arb #(.AW(16), .DW(32), .WAIT_CYC(0)) u_dut_b (
        .clk(clk), .rst_f(rst_f),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
        .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
        .dm_ack(b_dm_ack), .dm_rdata(b_dm_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    // Memory models: synchronous write, registered read.
    always @(posedge clk) begin
        if (a_mem_en) begin
            if (a_mem_we) mem_a[a_mem_addr[7:0]] <= a_mem_wdata;
            a_mem_rdata <= mem_a[a_mem_addr[7:0]];
        end
    end

    always @(posedge clk) begin
        if (b_mem_en) begin
            if (b_mem_we) mem_b[b_mem_addr[7:0]] <= b_mem_wdata;
            b_mem_rdata <= mem_b[b_mem_addr[7:0]];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Waits (bounded) for the ack of one port on instance A, starting from an IDLE
    // cycle in which that port's request is already high. Checks the ack lands 3
    // cycles later (2 + WAIT_CYC), the other ack stays low and mem_en was high for
    // 2 cycles. Returns at the negedge of the ack cycle.
    task automatic a_wait_ack(input bit is_dm, input string tag, output int we_cycles);
        int k;
        int en;
        bit got;
        k = 0;
        en = 0;
        got = 1'b0;
        we_cycles = 0;
        while (!got && k < 20) begin
            @(negedge clk);
            if (is_dm ? a_dm_ack : a_if_ack) begin
                got = 1'b1;
                check({tag, "_other_ack"}, is_dm ? a_if_ack : a_dm_ack, 0);
                check({tag, "_latency"}, k, 3);
                check({tag, "_en_cycles"}, en, 2);
            end else begin
                en += int'(a_mem_en);
                we_cycles += int'(a_mem_we);
                k++;
            end
        end
        if (!got) check({tag, "_timeout"}, 0, 1);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          we_n;
        int          acks;
        int          kk [3];
        logic [31:0] exp_b [3];

        rst_f = 1'b0;
        a_if_req = 0; a_if_addr = '0; a_dm_req = 0; a_dm_we = 0; a_dm_addr = '0; a_dm_wdata = '0;
        b_if_req = 0; b_if_addr = '0; b_dm_req = 0; b_dm_we = 0; b_dm_addr = '0; b_dm_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        mem_a[8'h10] = 32'h1122_3344;
        mem_a[8'h30] = 32'hA0A0_A0A0;
        mem_a[8'h40] = 32'hB0B0_B0B0;
        mem_b[8'h01] = 32'h0101_0101;
        mem_b[8'h02] = 32'h0202_0202;
        mem_b[8'h03] = 32'h0303_0303;
        mem_b[8'h50] = 32'h5555_5555;
        mem_b[8'h60] = 32'h6666_6666;
        exp_b[0] = 32'h0101_0101;
        exp_b[1] = 32'h0202_0202;
        exp_b[2] = 32'h0303_0303;
        kk[0] = 0; kk[1] = 0; kk[2] = 0;

        // Reset state, while held and after release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", a_busy, 0);
        check("rst_if_ack", a_if_ack, 0);
        check("rst_dm_ack", a_dm_ack, 0);
        check("rst_mem_en", a_mem_en, 0);
        check("rst_if_rdata", a_if_rdata, 0);
        check("rst_dm_rdata", a_dm_rdata, 0);
        check("rst_b_busy", b_busy, 0);
        rst_f = 1'b1;
        @(negedge clk);
        check("post_rst_busy", a_busy, 0);
        check("post_rst_mem_en", a_mem_en, 0);

        // Simultaneous requests after reset: IF, DM, IF, DM.
        @(posedge clk); #1;
        a_if_req = 1; a_if_addr = 16'h0030;
        a_dm_req = 1; a_dm_addr = 16'h0040; a_dm_we = 0;
        a_wait_ack(1'b0, "t3_if1", we_n);
        check("t3_if1_rdata", a_if_rdata, 32'hA0A0_A0A0);
        check("t3_if1_dm_rdata", a_dm_rdata, 0);
        @(posedge clk); #1;
        a_if_req = 0;
        a_wait_ack(1'b1, "t3_dm1", we_n);
        check("t3_dm1_rdata", a_dm_rdata, 32'hB0B0_B0B0);
        check("t3_dm1_if_rdata", a_if_rdata, 32'hA0A0_A0A0);
        @(posedge clk); #1;
        a_if_req = 1; a_if_addr = 16'h0010;
        a_wait_ack(1'b0, "t3_if2", we_n);
        check("t3_if2_rdata", a_if_rdata, 32'h1122_3344);
        @(posedge clk); #1;
        a_if_req = 0;
        a_wait_ack(1'b1, "t3_dm2", we_n);
        @(posedge clk); #1;
        a_dm_req = 0;

        // Single fetch with WAIT_CYC=1; rdata held after the ack.
        @(negedge clk);
        @(posedge clk); #1;
        a_if_req = 1; a_if_addr = 16'h0010;
        a_wait_ack(1'b0, "t2", we_n);
        check("t2_we_cycles", we_n, 0);
        check("t2_rdata_ack", a_if_rdata, 32'h1122_3344);
        @(posedge clk); #1;
        a_if_req = 0;
        @(negedge clk);
        check("t2_ack_pulse", a_if_ack, 0);
        check("t2_idle", a_busy, 0);
        check("t2_rdata_hold", a_if_rdata, 32'h1122_3344);

        // Store then load back.
        @(posedge clk); #1;
        a_dm_req = 1; a_dm_we = 1; a_dm_addr = 16'h0020; a_dm_wdata = 32'hDEAD_BEEF;
        a_wait_ack(1'b1, "t4_st", we_n);
        check("t4_we_cycles", we_n, 1);
        check("t4_dm_rdata_kept", a_dm_rdata, 32'hB0B0_B0B0);
        check("t4_if_rdata_kept", a_if_rdata, 32'h1122_3344);
        @(posedge clk); #1;
        a_dm_req = 0; a_dm_we = 0; a_dm_wdata = '0;
        @(negedge clk);
        check("t4_mem_written", mem_a[8'h20], 32'hDEAD_BEEF);
        check("t4_dm_rdata_after", a_dm_rdata, 32'hB0B0_B0B0);
        @(posedge clk); #1;
        a_dm_req = 1; a_dm_addr = 16'h0020;
        a_wait_ack(1'b1, "t4_ld", we_n);
        check("t4_ld_rdata", a_dm_rdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        a_dm_req = 0;

        // Reset asserted in the middle of WAIT.
        @(posedge clk); #1;
        a_if_req = 1; a_if_addr = 16'h0030;
        @(negedge clk);
        @(negedge clk);
        check("t5_access_en", a_mem_en, 1);
        @(negedge clk);
        check("t5_wait_en", a_mem_en, 1);
        check("t5_wait_we", a_mem_we, 0);
        #1;
        rst_f = 1'b0;
        #1;
        check("t5_rst_mem_en", a_mem_en, 0);
        check("t5_rst_busy", a_busy, 0);
        check("t5_rst_if_ack", a_if_ack, 0);
        check("t5_rst_if_rdata", a_if_rdata, 0);
        check("t5_rst_dm_rdata", a_dm_rdata, 0);
        a_if_req = 0;
        @(negedge clk);
        check("t5_no_ack", a_if_ack, 0);
        rst_f = 1'b1;
        @(posedge clk); #1;
        a_if_req = 1; a_if_addr = 16'h0010;
        a_wait_ack(1'b0, "t5_after", we_n);
        check("t5_after_rdata", a_if_rdata, 32'h1122_3344);
        @(posedge clk); #1;
        a_if_req = 0;

        // WAIT_CYC=0: back-to-back loads with dm_req held high.
        @(posedge clk); #1;
        b_dm_req = 1; b_dm_we = 0; b_dm_addr = 16'h0001;
        acks = 0;
        for (int k = 0; k < 20 && acks < 3; k++) begin
            @(negedge clk);
            if (b_dm_ack) begin
                check("t6_data", b_dm_rdata, exp_b[acks]);
                kk[acks] = k;
                acks++;
                if (acks < 3) b_dm_addr = 16'(acks + 1);
                else b_dm_req = 0;
            end
        end
        check("t6_ack_count", acks, 3);
        check("t6_first_latency", kk[0], 2);
        check("t6_gap1", kk[1] - kk[0], 3);
        check("t6_gap2", kk[2] - kk[1], 3);
        check("t6_dm_rdata_hold", b_dm_rdata, 32'h0303_0303);

        // WAIT_CYC=0: fetch address changed after grant is ignored.
        @(posedge clk); #1;
        b_if_req = 1; b_if_addr = 16'h0050;
        @(posedge clk); #1;
        b_if_addr = 16'h0060;
        @(negedge clk);
        check("t6_access_en", b_mem_en, 1);
        check("t6_access_addr", b_mem_addr, 16'h0050);
        @(negedge clk);
        check("t6_if_ack", b_if_ack, 1);
        check("t6_done_mem_en", b_mem_en, 0);
        check("t6_if_rdata", b_if_rdata, 32'h5555_5555);
        @(posedge clk); #1;
        b_if_req = 0;
        @(negedge clk);
        check("t6_if_ack_pulse", b_if_ack, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
